// File: rtl/seat_pkg.sv
// Shared types and helpers for the seat occupancy tracker.
package seat_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        EVAC   = 2'd2
    } seat_state_e;

    // Minimum index width for n items, never narrower than one bit.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seat_channel_counter.sv
// Per-channel present counter with full/empty flags.
// Optional saturating total-entry counter when TOTAL_COUNT_EN is defined.
module seat_channel_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned CAPACITY = 15
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
`ifdef TOTAL_COUNT_EN
    ,
    output logic [CNT_W-1:0] o_total
`endif
);

    logic [CNT_W-1:0] r_count;

    // Guards keep the count inside [0, CAPACITY] even if both strobes misbehave.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_dec && !o_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(CAPACITY));
    assign o_empty = (r_count == '0);

`ifdef TOTAL_COUNT_EN
    logic [CNT_W-1:0] r_total;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_total <= '0;
        end else if (i_inc && !o_full && (r_total != '1)) begin
            r_total <= r_total + CNT_W'(1);
        end
    end

    assign o_total = r_total;
`endif

endmodule

// File: rtl/seat_occupancy_tracker.sv
// Multi-channel seat occupancy tracker with admission window and evacuation mode.
// Define TOTAL_COUNT_EN to add the per-channel total-entries output TC_B.
module seat_occupancy_tracker
    import seat_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned CAPACITY = 15,
    parameter int unsigned WINDOW   = 15
) (
    input  logic                        Clock,
    input  logic                        Clear,
    input  logic                        START,
    input  logic                        ALARM,
    input  logic                        Enter,
    input  logic                        Exit,
    input  logic [min_width(NUM_CH)-1:0] Ch,
    output logic                        Accept,
    output logic                        Reject,
    output logic [NUM_CH*CNT_W-1:0]     PC_B,
    output logic [NUM_CH-1:0]           VI,
    output logic                        EA_LED,
    output logic [STATE_W-1:0]          State
`ifdef TOTAL_COUNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]     TC_B
`endif
);

    localparam int unsigned WIN_W = min_width(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);

    seat_state_e      r_state;
    logic [WIN_W-1:0] r_win;
    logic             r_ea_led;
    logic             r_accept;
    logic             r_reject;

    logic [31:0]       w_ch_idx;
    logic              w_ch_valid;
    logic              w_sel_full;
    logic              w_sel_empty;
    logic              w_req;
    logic              w_enter_ok;
    logic              w_exit_ok;
    logic              w_accept;
    logic              w_all_empty;
    logic [NUM_CH-1:0] w_inc;
    logic [NUM_CH-1:0] w_dec;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;

    assign w_ch_idx   = 32'(Ch);
    assign w_ch_valid = (w_ch_idx < NUM_CH);

    always_comb begin
        w_sel_full  = 1'b0;
        w_sel_empty = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_idx == 32'(k)) begin
                w_sel_full  = w_full[k];
                w_sel_empty = w_empty[k];
            end
        end
    end

    // Requests see the pre-edge state, so the last OPEN cycle still admits.
    assign w_req       = Enter | Exit;
    assign w_enter_ok  = Enter & ~Exit & (r_state == OPEN) & w_ch_valid & ~w_sel_full;
    assign w_exit_ok   = Exit & ~Enter & w_ch_valid & ~w_sel_empty;
    assign w_accept    = w_enter_ok | w_exit_ok;
    assign w_all_empty = &w_empty;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state  <= CLOSED;
            r_win    <= '0;
            r_ea_led <= 1'b0;
        end else if (ALARM) begin
            r_state  <= EVAC;
            r_win    <= '0;
            r_ea_led <= 1'b1;
        end else begin
            case (r_state)
                CLOSED: begin
                    if (START) begin
                        r_state <= OPEN;
                        r_win   <= WIN_LOAD;
                    end
                end
                OPEN: begin
                    if (START) begin
                        r_win <= WIN_LOAD;
                    end else if (r_win == '0) begin
                        r_state <= CLOSED;
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
                EVAC: begin
                    if (w_all_empty) begin
                        r_state  <= CLOSED;
                        r_ea_led <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= CLOSED;
                    r_win    <= '0;
                    r_ea_led <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_accept <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_accept <= w_accept;
            r_reject <= w_req & ~w_accept;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_inc[g] = w_enter_ok & (w_ch_idx == 32'(g));
        assign w_dec[g] = w_exit_ok & (w_ch_idx == 32'(g));

        seat_channel_counter #(
            .CNT_W   (CNT_W),
            .CAPACITY(CAPACITY)
        ) u_cnt (
            .i_clk  (Clock),
            .i_clr  (Clear),
            .i_inc  (w_inc[g]),
            .i_dec  (w_dec[g]),
            .o_count(PC_B[g*CNT_W +: CNT_W]),
            .o_full (w_full[g]),
            .o_empty(w_empty[g])
`ifdef TOTAL_COUNT_EN
            ,
            .o_total(TC_B[g*CNT_W +: CNT_W])
`endif
        );
    end

    assign VI     = w_full;
    assign Accept = r_accept;
    assign Reject = r_reject;
    assign EA_LED = r_ea_led;
    assign State  = r_state;

endmodule

// File: tb/tb_seat_occupancy_tracker.sv
// Directed self-checking bench for seat_occupancy_tracker.
// NUM_CH=5 so that Ch=NUM_CH is representable on the 3-bit select.
module tb_seat_occupancy_tracker;

    localparam int unsigned NUM_CH   = 5;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CAPACITY = 15;
    localparam int unsigned WINDOW   = 15;

    logic                    Clock = 1'b0;
    logic                    Clear = 1'b0;
    logic                    START = 1'b0;
    logic                    ALARM = 1'b0;
    logic                    Enter = 1'b0;
    logic                    Exit  = 1'b0;
    logic [2:0]              Ch    = '0;
    logic                    Accept;
    logic                    Reject;
    logic [NUM_CH*CNT_W-1:0] PC_B;
    logic [NUM_CH-1:0]       VI;
    logic                    EA_LED;
    logic [1:0]              State;
`ifdef TOTAL_COUNT_EN
    logic [NUM_CH*CNT_W-1:0] TC_B;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seat_occupancy_tracker #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .CAPACITY(CAPACITY),
        .WINDOW  (WINDOW)
    ) dut (
        .Clock (Clock),
        .Clear (Clear),
        .START (START),
        .ALARM (ALARM),
        .Enter (Enter),
        .Exit  (Exit),
        .Ch    (Ch),
        .Accept(Accept),
        .Reject(Reject),
        .PC_B  (PC_B),
        .VI    (VI),
        .EA_LED(EA_LED),
        .State (State)
`ifdef TOTAL_COUNT_EN
        ,
        .TC_B  (TC_B)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic req(input logic en, input logic ex, input logic [2:0] ch);
        Enter = en;
        Exit  = ex;
        Ch    = ch;
        step();
        Enter = 1'b0;
        Exit  = 1'b0;
    endtask

    initial begin
        // Reset
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("rst_state", State, 0);
        check("rst_pcb", PC_B, 0);
        check("rst_vi", VI, 0);
        check("rst_acc", Accept, 0);
        check("rst_rej", Reject, 0);
        check("rst_led", EA_LED, 0);

        // Three entries on channel 1
        START = 1'b1;
        step();
        START = 1'b0;
        check("open_state", State, 1);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 3'd1);
            check("ch1_enter_acc", Accept, 1);
        end
        check("ch1_pcb", PC_B, 20'h00030);

        // Fill channel 0 to capacity, keep window reloaded with START
        START = 1'b1;
        for (int i = 0; i < 15; i++) req(1'b1, 1'b0, 3'd0);
        START = 1'b0;
        check("ch0_full_pcb", PC_B, 20'h0003F);
        check("ch0_full_vi", VI, 5'b00001);
        req(1'b1, 1'b0, 3'd0);
        check("ovf_rej", Reject, 1);
        check("ovf_acc", Accept, 0);
        check("ovf_vi", VI, 5'b00001);
        check("ovf_pcb", PC_B, 20'h0003F);
        req(1'b0, 1'b1, 3'd0);
        check("ch0_exit_acc", Accept, 1);
        check("ch0_exit_pcb", PC_B, 20'h0003E);
        check("ch0_exit_vi", VI, 5'b00000);

        // Request on the closing edge is still evaluated as OPEN
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (14) step();
        check("last_open_cycle", State, 1);
        req(1'b1, 1'b0, 3'd2);
        check("close_edge_acc", Accept, 1);
        check("close_edge_state", State, 0);
        check("close_edge_pcb", PC_B, 20'h0013E);

        // Full window idle then closed behaviour
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (15) step();
        check("window_closed", State, 0);
        req(1'b1, 1'b0, 3'd1);
        check("closed_enter_rej", Reject, 1);
        req(1'b0, 1'b1, 3'd1);
        check("closed_exit_acc", Accept, 1);
        check("closed_exit_pcb", PC_B, 20'h0012E);

        // Clear in OPEN with counts overrides everything
        START = 1'b1;
        step();
        check("pre_clear_open", State, 1);
        Clear = 1'b1;
        Enter = 1'b1;
        Ch    = 3'd0;
        step();
        Clear = 1'b0;
        START = 1'b0;
        Enter = 1'b0;
        check("clr_state", State, 0);
        check("clr_pcb", PC_B, 0);
        check("clr_vi", VI, 0);
        check("clr_acc", Accept, 0);
        check("clr_rej", Reject, 0);
        check("clr_led", EA_LED, 0);

        // Evacuation on channel 2
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 5; i++) req(1'b1, 1'b0, 3'd2);
        check("ch2_five", PC_B, 20'h00500);
        ALARM = 1'b1;
        step();
        check("evac_state", State, 2);
        check("evac_led", EA_LED, 1);
        req(1'b1, 1'b0, 3'd2);
        check("evac_enter_rej", Reject, 1);
        ALARM = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        check("evac_start_ign", State, 2);
        for (int i = 0; i < 5; i++) begin
            req(1'b0, 1'b1, 3'd2);
            check("evac_exit_acc", Accept, 1);
        end
        check("evac_drained", PC_B, 0);
        check("evac_hold", State, 2);
        step();
        check("evac_closed", State, 0);
        check("evac_led_off", EA_LED, 0);

        // ALARM beats START
        ALARM = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        ALARM = 1'b0;
        check("alarm_prio", State, 2);
        step();
        check("alarm_clear_back", State, 0);

        // Reject corner cases
        START = 1'b1;
        step();
        START = 1'b0;
        req(1'b1, 1'b0, 3'd0);
        check("corner_enter_acc", Accept, 1);
        req(1'b1, 1'b1, 3'd0);
        check("both_rej", Reject, 1);
        check("both_acc", Accept, 0);
        check("both_pcb", PC_B, 20'h00001);
        req(1'b1, 1'b0, 3'd5);
        check("bad_ch_rej", Reject, 1);
        req(1'b0, 1'b1, 3'd3);
        check("empty_exit_rej", Reject, 1);
        check("empty_exit_pcb", PC_B, 20'h00001);
        step();
        check("idle_acc", Accept, 0);
        check("idle_rej", Reject, 0);

`ifdef TOTAL_COUNT_EN
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        START = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req(1'b1, 1'b0, 3'd3);
            req(1'b0, 1'b1, 3'd3);
        end
        START = 1'b0;
        check("tc_sat", TC_B, 20'h0F000);
        check("tc_pcb", PC_B, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
